// File: rtl/debouncer_bank.sv
// debouncer_bank: N-channel button conditioner. Each channel synchronises its raw
// pin, applies polarity, debounces with a saturating counter, and emits registered
// 1-cycle press/release strobes plus optional long-press and auto-repeat strobes.
//
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_rst          synchronous active-high reset
//   i_btn_in[N]    raw asynchronous pins, bit i = channel i
//   o_btn_state[N] debounced level, 1 = pressed
//   o_btn_down[N]  1-cycle strobe on debounced press
//   o_btn_up[N]    1-cycle strobe on debounced release
//   o_btn_hold[N]  1-cycle strobe HOLD_CYCLES after press, once per press
//   o_btn_repeat[N] 1-cycle auto-repeat strobe while held past the hold point
//   o_any_down     OR of o_btn_down across channels
module debouncer_bank #(
    parameter int unsigned N             = 4,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned ACTIVE_LOW    = 1,
    parameter int unsigned HOLD_CYCLES   = 0,
    parameter int unsigned REPEAT_CYCLES = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_btn_in,
    output logic [N-1:0] o_btn_state,
    output logic [N-1:0] o_btn_down,
    output logic [N-1:0] o_btn_up,
    output logic [N-1:0] o_btn_hold,
    output logic [N-1:0] o_btn_repeat,
    output logic         o_any_down
);

    localparam logic [N-1:0]     POL_MASK = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N-1:0]     r_s0;
    logic [N-1:0]     r_s1;
    logic [N-1:0]     r_state;
    logic [N-1:0]     r_down;
    logic [N-1:0]     r_up;
    logic             r_any_down;
    logic [CNT_W-1:0] r_cnt [N];
    logic [N-1:0]     w_toggle;

    // A channel flips when its counter saturates while s1 still disagrees with state.
    always_comb begin
        w_toggle = '0;
        for (int i = 0; i < N; i++) begin
            w_toggle[i] = (r_s1[i] != r_state[i]) && (r_cnt[i] == CNT_MAX);
        end
    end

    // Synchroniser, debounce counters, debounced state and edge strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s0       <= '0;
            r_s1       <= '0;
            r_state    <= '0;
            r_down     <= '0;
            r_up       <= '0;
            r_any_down <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s0       <= i_btn_in ^ POL_MASK;
            r_s1       <= r_s0;
            r_state    <= r_state ^ w_toggle;
            r_down     <= w_toggle & ~r_state;
            r_up       <= w_toggle & r_state;
            r_any_down <= |(w_toggle & ~r_state);
            // Counter wraps to 0 naturally on the toggle cycle.
            for (int i = 0; i < N; i++) begin
                if (r_s1[i] == r_state[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign o_btn_state = r_state;
    assign o_btn_down  = r_down;
    assign o_btn_up    = r_up;
    assign o_any_down  = r_any_down;

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int unsigned HCNT_W = $clog2(HOLD_CYCLES + 1);

        logic [HCNT_W-1:0] r_hcnt [N];
        logic [N-1:0]      r_hold;
        logic [N-1:0]      w_stay;
        logic [N-1:0]      w_hold_due;
        logic [N-1:0]      w_hold_sat;

        // w_stay: pressed now and not releasing on this edge (release wins over hold/repeat).
        always_comb begin
            w_stay     = r_state & ~w_toggle;
            w_hold_due = '0;
            w_hold_sat = '0;
            for (int i = 0; i < N; i++) begin
                w_hold_due[i] = w_stay[i] && (r_hcnt[i] == HCNT_W'(HOLD_CYCLES - 1));
                w_hold_sat[i] = (r_hcnt[i] == HCNT_W'(HOLD_CYCLES));
            end
        end

        // Hold counter runs from the cycle after the press edge and saturates.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_hold <= '0;
                for (int i = 0; i < N; i++) begin
                    r_hcnt[i] <= '0;
                end
            end else begin
                r_hold <= w_hold_due;
                for (int i = 0; i < N; i++) begin
                    if (!w_stay[i]) begin
                        r_hcnt[i] <= '0;
                    end else if (!w_hold_sat[i]) begin
                        r_hcnt[i] <= r_hcnt[i] + HCNT_W'(1);
                    end
                end
            end
        end

        assign o_btn_hold = r_hold;

        if (REPEAT_CYCLES > 0) begin : g_repeat
            localparam int unsigned RCNT_W = $clog2(REPEAT_CYCLES + 1);

            logic [RCNT_W-1:0] r_rcnt [N];
            logic [N-1:0]      r_repeat;
            logic [N-1:0]      w_rep_wrap;

            always_comb begin
                w_rep_wrap = '0;
                for (int i = 0; i < N; i++) begin
                    w_rep_wrap[i] = (r_rcnt[i] == RCNT_W'(REPEAT_CYCLES - 1));
                end
            end

            // Repeat phase counter only runs once the hold point has been passed.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    r_repeat <= '0;
                    for (int i = 0; i < N; i++) begin
                        r_rcnt[i] <= '0;
                    end
                end else begin
                    r_repeat <= w_hold_due | (w_stay & w_hold_sat & w_rep_wrap);
                    for (int i = 0; i < N; i++) begin
                        if (!w_stay[i] || !w_hold_sat[i] || w_rep_wrap[i]) begin
                            r_rcnt[i] <= '0;
                        end else begin
                            r_rcnt[i] <= r_rcnt[i] + RCNT_W'(1);
                        end
                    end
                end
            end

            assign o_btn_repeat = r_repeat;
        end else begin : g_no_repeat
            assign o_btn_repeat = '0;
        end
    end else begin : g_no_hold
        assign o_btn_hold   = '0;
        assign o_btn_repeat = '0;
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// Directed testbench for debouncer_bank with N=2, CNT_W=4, active-low pins,
// HOLD_CYCLES=40 and REPEAT_CYCLES=10.
module tb_debouncer_bank;

    localparam int unsigned N = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn_in;
    logic [N-1:0] o_btn_state;
    logic [N-1:0] o_btn_down;
    logic [N-1:0] o_btn_up;
    logic [N-1:0] o_btn_hold;
    logic [N-1:0] o_btn_repeat;
    logic         o_any_down;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int d_cyc  = 0;

    debouncer_bank #(
        .N             (2),
        .CNT_W         (4),
        .ACTIVE_LOW    (1),
        .HOLD_CYCLES   (40),
        .REPEAT_CYCLES (10)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_btn_in     (btn_in),
        .o_btn_state  (o_btn_state),
        .o_btn_down   (o_btn_down),
        .o_btn_up     (o_btn_up),
        .o_btn_hold   (o_btn_hold),
        .o_btn_repeat (o_btn_repeat),
        .o_any_down   (o_any_down)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the edge, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [10:0] acc;
        rst    = 1'b1;
        btn_in = 2'b11;
        repeat (3) step();
        checks++;
        if ({o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down} !== 11'b0)
            $display("FAIL reset_outputs: got %b expected 0",
                     {o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down});
        if ({o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down} !== 11'b0)
            errors++;
        rst = 1'b0;
        acc = '0;
        repeat (100) begin
            step();
            acc |= {o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down};
        end
        checks++;
        if (acc !== 11'b0) begin
            errors++;
            $display("FAIL reset_idle: accumulated outputs %b expected 0", acc);
        end
    endtask

    task automatic test_bounce();
        logic [10:0] acc;
        acc = '0;
        for (int k = 0; k < 200; k++) begin
            btn_in[0] = ((k / 8) % 2 == 0) ? 1'b0 : 1'b1;
            step();
            acc |= {o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down};
        end
        btn_in[0] = 1'b1;
        repeat (20) begin
            step();
            acc |= {o_btn_state, o_btn_down, o_btn_up, o_btn_hold, o_btn_repeat, o_any_down};
        end
        checks++;
        if (acc !== 11'b0) begin
            errors++;
            $display("FAIL bounce_rejected: accumulated outputs %b expected 0", acc);
        end
    endtask

    task automatic test_press();
        int          down_at  = -1;
        int          any_at   = -1;
        int          state_at = -1;
        int          ndown    = 0;
        logic [4:0]  ch1acc   = '0;
        btn_in[0] = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (o_btn_down[0] === 1'b1) begin
                ndown++;
                if (down_at < 0) begin
                    down_at = k;
                    d_cyc   = cyc;
                end
            end
            if (o_any_down === 1'b1 && any_at < 0) any_at = k;
            if (o_btn_state[0] === 1'b1 && state_at < 0) state_at = k;
            ch1acc |= {o_btn_state[1], o_btn_down[1], o_btn_up[1], o_btn_hold[1], o_btn_repeat[1]};
        end
        checks++;
        if (down_at != 18) begin
            errors++;
            $display("FAIL press_down_latency: got %0d expected 18", down_at);
        end
        checks++;
        if (ndown != 1) begin
            errors++;
            $display("FAIL press_down_count: got %0d expected 1", ndown);
        end
        checks++;
        if (any_at != 18) begin
            errors++;
            $display("FAIL press_any_down: got %0d expected 18", any_at);
        end
        checks++;
        if (state_at != 18) begin
            errors++;
            $display("FAIL press_state_latency: got %0d expected 18", state_at);
        end
        checks++;
        if (ch1acc !== 5'b0) begin
            errors++;
            $display("FAIL press_ch1_quiet: got %b expected 0", ch1acc);
        end
    endtask

    task automatic test_hold_repeat();
        int hold_off[$];
        int rep_off[$];
        int got;
        while (cyc < d_cyc + 102) begin
            step();
            if (o_btn_hold[0] === 1'b1) hold_off.push_back(cyc - d_cyc);
            if (o_btn_repeat[0] === 1'b1) rep_off.push_back(cyc - d_cyc);
        end
        checks++;
        if (hold_off.size() != 1) begin
            errors++;
            $display("FAIL hold_count: got %0d expected 1", hold_off.size());
        end
        got = (hold_off.size() > 0) ? hold_off[0] : -1;
        checks++;
        if (got != 40) begin
            errors++;
            $display("FAIL hold_offset: got %0d expected 40", got);
        end
        checks++;
        if (rep_off.size() != 7) begin
            errors++;
            $display("FAIL repeat_count: got %0d expected 7", rep_off.size());
        end
        for (int i = 0; i < 7; i++) begin
            got = (i < rep_off.size()) ? rep_off[i] : -1;
            checks++;
            if (got != 40 + 10 * i) begin
                errors++;
                $display("FAIL repeat_offset_%0d: got %0d expected %0d", i, got, 40 + 10 * i);
            end
        end
    endtask

    // Release is timed so the debounced release lands on the edge a repeat would be due.
    task automatic test_release();
        int up_off[$];
        int rep_off[$];
        int got;
        int overlap = 0;
        btn_in[0] = 1'b1;
        while (cyc < d_cyc + 140) begin
            step();
            if (o_btn_up[0] === 1'b1) up_off.push_back(cyc - d_cyc);
            if (o_btn_repeat[0] === 1'b1) rep_off.push_back(cyc - d_cyc);
            if ((o_btn_up & o_btn_down) !== 2'b00) overlap++;
        end
        checks++;
        if (up_off.size() != 1) begin
            errors++;
            $display("FAIL release_up_count: got %0d expected 1", up_off.size());
        end
        got = (up_off.size() > 0) ? up_off[0] : -1;
        checks++;
        if (got != 120) begin
            errors++;
            $display("FAIL release_up_offset: got %0d expected 120", got);
        end
        checks++;
        if (rep_off.size() != 1) begin
            errors++;
            $display("FAIL release_repeat_count: got %0d expected 1", rep_off.size());
        end
        got = (rep_off.size() > 0) ? rep_off[0] : -1;
        checks++;
        if (got != 110) begin
            errors++;
            $display("FAIL release_repeat_offset: got %0d expected 110", got);
        end
        checks++;
        if (o_btn_state !== 2'b00) begin
            errors++;
            $display("FAIL release_state: got %b expected 00", o_btn_state);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL release_up_down_overlap: got %0d expected 0", overlap);
        end
    endtask

    task automatic test_back_to_back();
        int           down_at = -1;
        int           any_at  = -1;
        int           ncyc    = 0;
        logic [N-1:0] vec     = '0;
        btn_in = 2'b00;
        for (int k = 1; k <= 30; k++) begin
            step();
            if (o_btn_down !== 2'b00) begin
                ncyc++;
                if (down_at < 0) begin
                    down_at = k;
                    vec     = o_btn_down;
                end
            end
            if (o_any_down === 1'b1 && any_at < 0) any_at = k;
        end
        checks++;
        if (vec !== 2'b11) begin
            errors++;
            $display("FAIL both_down_vector: got %b expected 11", vec);
        end
        checks++;
        if (down_at != 18 || ncyc != 1) begin
            errors++;
            $display("FAIL both_down_timing: got at=%0d cycles=%0d expected at=18 cycles=1",
                     down_at, ncyc);
        end
        checks++;
        if (any_at != 18) begin
            errors++;
            $display("FAIL both_any_down: got %0d expected 18", any_at);
        end
        checks++;
        if (o_btn_state !== 2'b11) begin
            errors++;
            $display("FAIL both_state: got %b expected 11", o_btn_state);
        end
    endtask

    task automatic test_reset_mid_press();
        int           down_at = -1;
        int           nup     = 0;
        logic [N-1:0] vec     = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({o_btn_state, o_btn_down, o_btn_up} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_clear: got %b expected 0", {o_btn_state, o_btn_down, o_btn_up});
        end
        for (int k = 1; k <= 30; k++) begin
            step();
            if (o_btn_up !== 2'b00) nup++;
            if (o_btn_down !== 2'b00 && down_at < 0) begin
                down_at = k;
                vec     = o_btn_down;
            end
        end
        checks++;
        if (nup != 0) begin
            errors++;
            $display("FAIL midreset_no_up: got %0d up cycles expected 0", nup);
        end
        checks++;
        if (down_at != 18 || vec !== 2'b11) begin
            errors++;
            $display("FAIL midreset_fresh_down: got at=%0d vec=%b expected at=18 vec=11",
                     down_at, vec);
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 2'b11;
        test_reset();
        test_bounce();
        test_press();
        test_hold_repeat();
        test_release();
        test_back_to_back();
        test_reset_mid_press();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
